// File: rtl/k423_if_fetch_pkg.sv
// k423 fetch package: drain FSM states, queue entry layout,
// and the misalignment helper.
`include "k423_defines.svh"
package k423_if_fetch_pkg;

    typedef enum logic {
        RUN,
        DRAIN
    } k423_fetch_st_e;

    typedef struct packed {
        logic [`CORE_ADDR_W-1:0] pc;
        logic [`CORE_DATA_W-1:0] inst;
        logic                    misalign;
    } k423_entry_t;

    function automatic logic k423_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/k423_if_fetch_if.sv
// k423 fetch stage bundle: PC-gen handshake, imem request/response,
// ID handshake and pipeline control.
`include "k423_defines.svh"
interface k423_if_fetch_if #(
    parameter int ADDR_W = `CORE_ADDR_W,
    parameter int DATA_W = `CORE_DATA_W
);
    logic              pc_stage_vld_i;
    logic [ADDR_W-1:0] pc_i;
    logic              if_stage_rdy_o;
    logic              pcu_flush_if_i;
    logic              pcu_stall_if_i;
    logic              imem_req_vld_o;
    logic              imem_req_rdy_i;
    logic [ADDR_W-1:0] imem_req_addr_o;
    logic              imem_rsp_vld_i;
    logic [DATA_W-1:0] imem_rsp_data_i;
    logic              if_stage_vld_o;
    logic [ADDR_W-1:0] if_pc_o;
    logic [DATA_W-1:0] if_inst_o;
    logic              if_misalign_o;
    logic              id_stage_rdy_i;

    modport slave (
        input  pc_stage_vld_i, pc_i, pcu_flush_if_i, pcu_stall_if_i,
        input  imem_req_rdy_i, imem_rsp_vld_i, imem_rsp_data_i,
        input  id_stage_rdy_i,
        output if_stage_rdy_o, imem_req_vld_o, imem_req_addr_o,
        output if_stage_vld_o, if_pc_o, if_inst_o, if_misalign_o
    );

    modport master (
        output pc_stage_vld_i, pc_i, pcu_flush_if_i, pcu_stall_if_i,
        output imem_req_rdy_i, imem_rsp_vld_i, imem_rsp_data_i,
        output id_stage_rdy_i,
        input  if_stage_rdy_o, imem_req_vld_o, imem_req_addr_o,
        input  if_stage_vld_o, if_pc_o, if_inst_o, if_misalign_o
    );

endinterface

// File: rtl/k423_defines.svh
// k423 core-wide width defaults shared by the fetch slice.
`ifndef K423_DEFINES_SVH
`define K423_DEFINES_SVH
`define CORE_ADDR_W 32
`define CORE_DATA_W 32
`endif

// File: rtl/k423_sync_fifo.sv
// k423 synchronous FIFO: power-of-2 depth, sync clear, occupancy count.
// Callers guarantee no push on full without pop and no pop on empty.
module k423_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dout,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || i_clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (i_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rp];
    assign o_count = r_cnt;

endmodule

// File: rtl/k423_if_fetch.sv
// k423 IF stage: in-order imem fetch with PC tags, instruction queue
// to ID, flush drops responses still owed to discarded requests.
`include "k423_defines.svh"
module k423_if_fetch
    import k423_if_fetch_pkg::*;
#(
    parameter int ADDR_W = `CORE_ADDR_W,
    parameter int DATA_W = `CORE_DATA_W,
    parameter int QDEPTH = 2
) (
    input logic            clk_i,
    input logic            rst_i,
    k423_if_fetch_if.slave bus
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] L_QDEPTH = (CW+1)'(QDEPTH);

    k423_fetch_st_e    r_st;
    logic [CW-1:0]     r_drop_cnt;
    logic              r_hold_vld;
    logic [ADDR_W-1:0] r_hold_pc;

    logic [CW-1:0]     w_out_cnt;
    logic [CW-1:0]     w_q_cnt;
    logic [CW-1:0]     w_out_nxt;
    logic [CW-1:0]     w_drop_nxt;
    logic              w_mis;
    logic              w_credit;
    logic              w_open;
    logic              w_issue;
    logic              w_req_acc;
    logic              w_mis_acc;
    logic              w_rsp_drop;
    logic              w_rsp_keep;
    logic              w_hold_go;
    logic              w_mis_direct;
    logic              w_q_push;
    logic              w_q_pop;
    logic              w_q_vld;
    logic [ADDR_W-1:0] w_tag;
    k423_entry_t       w_q_din;
    k423_entry_t       w_q_dout;

    // Every request in flight owns a queue slot; the hold register blocks
    assign w_mis    = k423_misaligned(bus.pc_i[1:0]);
    assign w_credit = !r_hold_vld &&
                      (({1'b0, w_out_cnt} + {1'b0, w_q_cnt}) < L_QDEPTH);
    assign w_open   = w_credit && !bus.pcu_stall_if_i &&
                      !bus.pcu_flush_if_i;

    assign w_issue   = bus.pc_stage_vld_i && w_open && !w_mis;
    assign w_req_acc = w_issue && bus.imem_req_rdy_i;
    assign w_mis_acc = bus.pc_stage_vld_i && w_open && w_mis;

    assign bus.imem_req_vld_o  = w_issue;
    assign bus.imem_req_addr_o = {bus.pc_i[ADDR_W-1:2], 2'b00};
    assign bus.if_stage_rdy_o  = w_open &&
                                 (w_mis || bus.imem_req_rdy_i);

    assign w_rsp_drop   = bus.imem_rsp_vld_i && (r_st == DRAIN);
    assign w_rsp_keep   = bus.imem_rsp_vld_i && (r_st == RUN);
    assign w_hold_go    = r_hold_vld && (w_out_cnt == '0);
    assign w_mis_direct = w_mis_acc && (w_out_cnt == '0);

    assign w_q_push = w_rsp_keep || w_hold_go || w_mis_direct;
    assign w_q_vld  = (w_q_cnt != '0);
    assign w_q_pop  = w_q_vld && bus.id_stage_rdy_i &&
                      !bus.pcu_flush_if_i;

    always_comb begin
        w_q_din          = '0;
        w_q_din.misalign = 1'b1;
        if (w_rsp_keep) begin
            w_q_din.pc       = w_tag;
            w_q_din.inst     = bus.imem_rsp_data_i;
            w_q_din.misalign = 1'b0;
        end else if (w_hold_go) begin
            w_q_din.pc = r_hold_pc;
        end else begin
            w_q_din.pc = bus.pc_i;
        end
    end

    // Flush counts this cycle's response before reloading the drop count
    assign w_out_nxt  = w_out_cnt - CW'(bus.imem_rsp_vld_i);
    assign w_drop_nxt = bus.pcu_flush_if_i ? w_out_nxt :
                        r_drop_cnt - CW'(w_rsp_drop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_st       <= RUN;
            r_drop_cnt <= '0;
            r_hold_vld <= 1'b0;
            r_hold_pc  <= '0;
        end else begin
            r_drop_cnt <= w_drop_nxt;
            unique case (r_st)
                RUN:   if (w_drop_nxt != '0) r_st <= DRAIN;
                DRAIN: if (w_drop_nxt == '0) r_st <= RUN;
            endcase
            if (bus.pcu_flush_if_i || w_hold_go) begin
                r_hold_vld <= 1'b0;
            end else if (w_mis_acc && !w_mis_direct) begin
                r_hold_vld <= 1'b1;
                r_hold_pc  <= bus.pc_i;
            end
        end
    end

    k423_sync_fifo #(
        .W     (ADDR_W),
        .DEPTH (QDEPTH)
    ) u_tag (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_clr   (1'b0),
        .i_push  (w_req_acc),
        .i_din   (bus.pc_i),
        .i_pop   (bus.imem_rsp_vld_i),
        .o_dout  (w_tag),
        .o_count (w_out_cnt)
    );

    k423_sync_fifo #(
        .W     ($bits(k423_entry_t)),
        .DEPTH (QDEPTH)
    ) u_iq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_clr   (bus.pcu_flush_if_i),
        .i_push  (w_q_push),
        .i_din   (w_q_din),
        .i_pop   (w_q_pop),
        .o_dout  (w_q_dout),
        .o_count (w_q_cnt)
    );

    assign bus.if_stage_vld_o = w_q_vld;
    assign bus.if_pc_o        = w_q_dout.pc;
    assign bus.if_inst_o      = w_q_dout.inst;
    assign bus.if_misalign_o  = w_q_vld && w_q_dout.misalign;

endmodule

// File: tb/tb_k423_if_fetch.sv
// k423 IF stage bench: random PC/imem/ID traffic against a queue-level
// model of accepted-but-not-flushed PCs, plus directed corner cases.
module tb_k423_if_fetch;
    import k423_if_fetch_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    k423_if_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    k423_if_fetch #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .QDEPTH (QD)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    k423_entry_t exp_q[$];
    logic [31:0] mem_q[$];
    int          rsp_cyc[logic [31:0]];
    logic        lat_on = 1'b0;
    logic        force_flush = 1'b0;
    logic [31:0] next_pc = 32'h8000_0000;
    int p_pcv, p_rrdy, p_rsp, p_idr, p_stall, p_flush, p_mis;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic knobs(input int pcv, input int rrdy, input int rsp,
                         input int idr, input int stall, input int fl,
                         input int mis);
        p_pcv = pcv; p_rrdy = rrdy; p_rsp = rsp; p_idr = idr;
        p_stall = stall; p_flush = fl; p_mis = mis;
    endtask

    task automatic drive_idle();
        bus.pc_stage_vld_i  = 1'b0;
        bus.pc_i            = '0;
        bus.pcu_flush_if_i  = 1'b0;
        bus.pcu_stall_if_i  = 1'b0;
        bus.imem_req_rdy_i  = 1'b0;
        bus.imem_rsp_vld_i  = 1'b0;
        bus.imem_rsp_data_i = '0;
        bus.id_stage_rdy_i  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        mem_q.delete();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic observe();
        logic [31:0] pc;
        logic        mis;
        pc  = bus.pc_i;
        mis = (pc[1:0] != 2'b00);
        if (bus.imem_req_vld_o) begin
            chk("req_addr", 64'(bus.imem_req_addr_o), 64'({pc[31:2], 2'b00}));
        end
        if (bus.pc_stage_vld_i && mis) begin
            chk("mis_no_req", 64'(bus.imem_req_vld_o), 64'(0));
        end
        if (bus.imem_rsp_vld_i) begin
            rsp_cyc[mem_q[0]] = cyc;
            void'(mem_q.pop_front());
        end
        if (bus.imem_req_vld_o && bus.imem_req_rdy_i) begin
            mem_q.push_back(bus.imem_req_addr_o);
        end
        if (bus.pcu_flush_if_i) begin
            exp_q.delete();
            if (roll(50)) next_pc = {16'h8000, 14'($urandom), 2'b00};
        end else if (bus.pc_stage_vld_i && bus.if_stage_rdy_o) begin
            exp_q.push_back('{pc: pc, inst: (mis ? 32'h0 : memf(pc)),
                              misalign: mis});
            next_pc = {pc[31:2] + 30'd1,
                       (roll(p_mis) ? 2'($urandom_range(3, 1)) : 2'b00)};
        end
        n_chk++;
        if (dut.w_q_push && !bus.pcu_flush_if_i && !dut.w_q_pop &&
            dut.w_q_cnt == 2'(QD)) begin
            n_err++;
            $display("FAIL queue_overflow: count %0d at limit %0d", dut.w_q_cnt, QD);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        bus.pc_stage_vld_i  = roll(p_pcv);
        bus.pc_i            = next_pc;
        bus.imem_req_rdy_i  = roll(p_rrdy);
        bus.imem_rsp_vld_i  = 1'b0;
        bus.imem_rsp_data_i = '0;
        if (mem_q.size() > 0 && roll(p_rsp)) begin
            bus.imem_rsp_vld_i  = 1'b1;
            bus.imem_rsp_data_i = memf(mem_q[0]);
        end
        bus.id_stage_rdy_i = roll(p_idr);
        bus.pcu_stall_if_i = roll(p_stall);
        bus.pcu_flush_if_i = force_flush | roll(p_flush);
        force_flush = 1'b0;
        #1;
        observe();
    endtask

    // Monitor: pops the model queue whenever ID takes an entry
    initial begin
        k423_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.if_stage_vld_o && bus.id_stage_rdy_i &&
                !bus.pcu_flush_if_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_out: pc %h, expected none", bus.if_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", 64'(bus.if_pc_o), 64'(e.pc));
                    chk("out_inst", 64'(bus.if_inst_o), 64'(e.inst));
                    chk("out_mis", 64'(bus.if_misalign_o), 64'(e.misalign));
                    if (lat_on) begin
                        chk("latency", 64'(cyc), 64'(rsp_cyc[e.pc] + 1));
                    end
                end
            end
        end
    end

    initial begin
        int k;
        drive_idle();
        knobs(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        #1;
        chk("rst_vld", 64'(bus.if_stage_vld_o), 64'(0));
        chk("rst_req", 64'(bus.imem_req_vld_o), 64'(0));
        chk("rst_mis", 64'(bus.if_misalign_o), 64'(0));
        chk("rst_out", 64'(dut.w_out_cnt), 64'(0));
        chk("rst_drop", 64'(dut.r_drop_cnt), 64'(0));

        next_pc = 32'h8000_0000;
        knobs(100, 100, 100, 100, 0, 0, 0);
        lat_on = 1'b1;
        repeat (30) step();
        lat_on = 1'b0;

        knobs(100, 100, 100, 0, 0, 0, 0);
        repeat (6) step();
        chk("bp_rdy", 64'(bus.if_stage_rdy_o), 64'(0));
        chk("bp_req", 64'(bus.imem_req_vld_o), 64'(0));
        chk("bp_vld", 64'(bus.if_stage_vld_o), 64'(1));
        knobs(100, 100, 100, 100, 0, 0, 0);
        repeat (20) step();

        knobs(0, 100, 100, 100, 0, 0, 0);
        repeat (8) step();
        knobs(100, 100, 0, 100, 0, 0, 0);
        repeat (4) step();
        chk("fl_inflight", 64'(dut.w_out_cnt), 64'(2));
        knobs(0, 100, 0, 100, 0, 0, 0);
        force_flush = 1'b1;
        step();
        knobs(0, 100, 100, 100, 0, 0, 0);
        step();
        chk("fl_drain", 64'(dut.r_st == DRAIN), 64'(1));
        chk("fl_dropcnt", 64'(dut.r_drop_cnt), 64'(2));
        repeat (3) step();
        chk("fl_run", 64'(dut.r_st == RUN), 64'(1));
        chk("fl_novld", 64'(bus.if_stage_vld_o), 64'(0));
        next_pc = 32'h8000_0100;
        knobs(100, 100, 100, 100, 0, 0, 0);
        step();
        knobs(0, 100, 100, 100, 0, 0, 0);
        repeat (5) step();

        knobs(100, 100, 0, 0, 0, 0, 0);
        repeat (3) step();
        knobs(0, 100, 100, 0, 0, 0, 0);
        step();
        knobs(0, 100, 100, 100, 0, 0, 0);
        force_flush = 1'b1;
        step();
        chk("flc_head", 64'(bus.if_stage_vld_o), 64'(1));
        knobs(0, 100, 0, 0, 0, 0, 0);
        step();
        chk("flc_empty", 64'(bus.if_stage_vld_o), 64'(0));
        chk("flc_out", 64'(dut.w_out_cnt), 64'(0));
        chk("flc_run", 64'(dut.r_st == RUN), 64'(1));

        next_pc = 32'h8000_0004;
        knobs(100, 100, 0, 100, 0, 0, 0);
        step();
        next_pc = 32'h8000_0006;
        step();
        chk("mis_rdy", 64'(bus.if_stage_rdy_o), 64'(1));
        chk("mis_req", 64'(bus.imem_req_vld_o), 64'(0));
        knobs(0, 100, 100, 100, 0, 0, 0);
        repeat (6) step();
        chk("mis_done", 64'(exp_q.size()), 64'(0));

        knobs(100, 100, 100, 0, 0, 0, 0);
        repeat (5) step();
        knobs(100, 100, 100, 100, 100, 0, 0);
        repeat (6) begin
            step();
            chk("stall_noreq", 64'(bus.imem_req_vld_o), 64'(0));
        end
        chk("stall_drained", 64'(bus.if_stage_vld_o), 64'(0));

        knobs(100, 100, 0, 100, 0, 0, 0);
        repeat (3) step();
        knobs(0, 100, 0, 100, 0, 0, 0);
        force_flush = 1'b1;
        step();
        step();
        chk("rd_drain", 64'(dut.r_st == DRAIN), 64'(1));
        do_reset();
        #1;
        chk("rd_vld", 64'(bus.if_stage_vld_o), 64'(0));
        chk("rd_mis", 64'(bus.if_misalign_o), 64'(0));
        chk("rd_out", 64'(dut.w_out_cnt), 64'(0));
        chk("rd_drop", 64'(dut.r_drop_cnt), 64'(0));
        chk("rd_run", 64'(dut.r_st == RUN), 64'(1));

        knobs(70, 70, 60, 70, 10, 3, 8);
        repeat (3000) step();

        knobs(0, 100, 100, 100, 0, 0, 0);
        k = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && k < 200) begin
            step();
            k++;
        end
        step();
        chk("end_exp_empty", 64'(exp_q.size()), 64'(0));
        chk("end_mem_empty", 64'(mem_q.size()), 64'(0));
        chk("end_vld", 64'(bus.if_stage_vld_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
